// File: rtl/pid_sequencer.sv
// Steps a fixed PID program ROM, driving operand/destination selects and AluOp to the register bank/ALU.
// Cost per ALU instruction is ALU_LAT+2 cycles (NOP 1), and Start is ignored while Busy because runs are never queued.
module pid_sequencer #(
  parameter int          PROG_LEN    = 8,
  parameter int          ALU_LAT     = 2,
  parameter int          PATCH_PC    = 16,
  parameter logic [15:0] PATCH_INSTR = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [1:0] AluOp,
  output logic [3:0] RsAddrs,
  output logic [3:0] RtAddrs,
  output logic [3:0] RdAddrs,
  output logic       WtReg
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WRITE, S_DONE} state_t;

  localparam logic [4:0] LP_LEN    = 5'(PROG_LEN);
  localparam logic [2:0] LP_LAT_M1 = 3'(ALU_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_pc;
  logic [2:0]  r_cnt;
  logic [3:0]  r_rs, r_rt, r_rd;
  logic [1:0]  r_aluop;
  logic        r_err;

  logic [15:0] w_instr;
  logic [3:0]  w_op;
  logic        w_is_alu, w_is_halt, w_last, w_rd_legal;
  logic [4:0]  w_pc_next;

  // Program: e = REF-POT; scaled P and I terms summed into t2/PWM. Entries 8..15 are NOP.
  function automatic logic [15:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    rom_word = 16'h3312;
      4'd1:    rom_word = 16'h4834;
      4'd2:    rom_word = 16'h2773;
      4'd3:    rom_word = 16'h4975;
      4'd4:    rom_word = 16'h2889;
      4'd5:    rom_word = 16'h4936;
      4'd6:    rom_word = 16'h2A89;
      4'd7:    rom_word = 16'h1BA0;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  assign w_instr    = (PATCH_PC == int'(r_pc)) ? PATCH_INSTR : rom_word(r_pc[3:0]);
  assign w_op       = w_instr[15:12];
  assign w_is_alu   = (w_op >= 4'd1) && (w_op <= 4'd4);
  assign w_is_halt  = (w_op == 4'd5);
  assign w_pc_next  = r_pc + 5'd1;
  assign w_last     = (w_pc_next == LP_LEN);
  assign w_rd_legal = (r_rd >= 4'd3) && (r_rd <= 4'd11);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_is_halt)     w_state_nxt = S_DONE;
        else if (w_is_alu) w_state_nxt = S_ISSUE;
        else if (w_last)   w_state_nxt = S_DONE;
        else               w_state_nxt = S_FETCH;
      end
      S_ISSUE: if (r_cnt == LP_LAT_M1) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy  = (r_state != S_IDLE);
    Done  = (r_state == S_DONE);
    WtReg = (r_state == S_WRITE) && w_rd_legal;
  end

  // Selects are captured on the FETCH edge so they are stable from the first ISSUE cycle through WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_cnt   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_aluop <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Start) begin
          r_pc  <= '0;
          r_err <= 1'b0;
        end
        S_FETCH: begin
          r_cnt <= '0;
          if (w_is_alu) begin
            r_rd    <= w_instr[11:8];
            r_rs    <= w_instr[7:4];
            r_rt    <= w_instr[3:0];
            r_aluop <= 2'(w_op - 4'd1);
          end else if (!w_is_halt) begin
            r_pc <= w_pc_next;
          end
        end
        S_ISSUE: r_cnt <= r_cnt + 3'd1;
        S_WRITE: begin
          r_pc <= w_pc_next;
          if (!w_rd_legal) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Err     = r_err;
  assign AluOp   = r_aluop;
  assign RsAddrs = r_rs;
  assign RtAddrs = r_rt;
  assign RdAddrs = r_rd;

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed bench: default program, a program with rd=0 at instr 1, and a program with HALT at instr 3.
module tb_pid_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [3];
  logic       busy  [3];
  logic       done  [3];
  logic       err   [3];
  logic       wtreg [3];
  logic [1:0] aluop [3];
  logic [3:0] rs    [3];
  logic [3:0] rt    [3];
  logic [3:0] rd    [3];

  int errors = 0;
  int checks = 0;

  int   n_wr, done_cyc, busy_bad;
  logic busy_after, err_done, err_c1;
  int   wr_rd  [16];
  int   wr_cyc [16];

  pid_sequencer #(.PROG_LEN(8), .ALU_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .Start(start[0]), .Busy(busy[0]), .Done(done[0]), .Err(err[0]),
    .AluOp(aluop[0]), .RsAddrs(rs[0]), .RtAddrs(rt[0]), .RdAddrs(rd[0]), .WtReg(wtreg[0]));

  pid_sequencer #(.PROG_LEN(8), .ALU_LAT(2), .PATCH_PC(1), .PATCH_INSTR(16'h4034)) u_rd0 (
    .clk(clk), .rst(rst), .Start(start[1]), .Busy(busy[1]), .Done(done[1]), .Err(err[1]),
    .AluOp(aluop[1]), .RsAddrs(rs[1]), .RtAddrs(rt[1]), .RdAddrs(rd[1]), .WtReg(wtreg[1]));

  pid_sequencer #(.PROG_LEN(8), .ALU_LAT(2), .PATCH_PC(3), .PATCH_INSTR(16'h5000)) u_halt (
    .clk(clk), .rst(rst), .Start(start[2]), .Busy(busy[2]), .Done(done[2]), .Err(err[2]),
    .AluOp(aluop[2]), .RsAddrs(rs[2]), .RtAddrs(rt[2]), .RdAddrs(rd[2]), .WtReg(wtreg[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle Start is high; cycle c is sampled 1ns after the c-th following edge.
  task automatic measure(input int idx, input bit poke);
    n_wr     = 0;
    done_cyc = -1;
    busy_bad = 0;
    err_done = 1'b0;
    err_c1   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_rd[i]  = -1;
      wr_cyc[i] = -1;
    end
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      if (c == 1) err_c1 = err[idx];
      if (busy[idx] !== 1'b1) busy_bad++;
      if (wtreg[idx] === 1'b1) begin
        if (n_wr < 16) begin
          wr_rd[n_wr]  = int'(rd[idx]);
          wr_cyc[n_wr] = c;
        end
        n_wr++;
      end
      if (done[idx] === 1'b1) begin
        done_cyc = c;
        err_done = err[idx];
      end else begin
        start[idx] = poke && (c % 7 == 3);
        tick();
      end
    end
    start[idx] = 1'b0;
    tick();
    busy_after = busy[idx];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (busy[0]  !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    checks++; if (done[0]  !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done[0]); end
    checks++; if (err[0]   !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err[0]); end
    checks++; if (wtreg[0] !== 1'b0)  begin errors++; $display("FAIL reset_wtreg: got %b want 0", wtreg[0]); end
    checks++; if ({aluop[0], rs[0], rt[0], rd[0]} !== 14'h0)
      begin errors++; $display("FAIL reset_sel: got op=%b rs=%0d rt=%0d rd=%0d want all 0", aluop[0], rs[0], rt[0], rd[0]); end
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy[0]); end
  endtask

  task automatic test_first_instr();
    int k;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1 || wtreg[0] !== 1'b0)
      begin errors++; $display("FAIL c1_busy: got busy=%b wt=%b want 1/0", busy[0], wtreg[0]); end
    tick();
    checks++; if (rs[0] !== 4'd1 || rt[0] !== 4'd2 || rd[0] !== 4'd3)
      begin errors++; $display("FAIL c2_addr: got rs=%0d rt=%0d rd=%0d want 1/2/3", rs[0], rt[0], rd[0]); end
    checks++; if (aluop[0] !== 2'b10) begin errors++; $display("FAIL c2_aluop: got %b want 10", aluop[0]); end
    checks++; if (wtreg[0] !== 1'b0) begin errors++; $display("FAIL c2_wtreg: got %b want 0", wtreg[0]); end
    tick();
    checks++; if (wtreg[0] !== 1'b0 || rs[0] !== 4'd1) begin errors++; $display("FAIL c3_hold: got wt=%b rs=%0d want 0/1", wtreg[0], rs[0]); end
    tick();
    checks++; if (wtreg[0] !== 1'b1 || rd[0] !== 4'd3) begin errors++; $display("FAIL c4_write: got wt=%b rd=%0d want 1/3", wtreg[0], rd[0]); end
    tick();
    checks++; if (wtreg[0] !== 1'b0) begin errors++; $display("FAIL c5_wtreg: got %b want 0", wtreg[0]); end
    k = 0;
    while (done[0] !== 1'b1 && k < 60) begin tick(); k++; end
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL first_drain: got done=%b want 1 within 60", done[0]); end
    tick();
  endtask

  task automatic test_full_run();
    int exp_rd [8];
    exp_rd = '{3, 8, 7, 9, 8, 9, 10, 11};
    measure(0, 1'b0);
    checks++; if (n_wr !== 8)      begin errors++; $display("FAIL full_nwr: got %0d want 8", n_wr); end
    checks++; if (done_cyc !== 33) begin errors++; $display("FAIL full_done: got %0d want 33", done_cyc); end
    checks++; if (busy_bad !== 0)  begin errors++; $display("FAIL full_busy: got %0d low cycles want 0", busy_bad); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b want 0", busy_after); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wr_rd[k] !== exp_rd[k] || wr_cyc[k] !== 4 + 4 * k)
        begin errors++; $display("FAIL full_wr%0d: got rd=%0d cyc=%0d want rd=%0d cyc=%0d", k, wr_rd[k], wr_cyc[k], exp_rd[k], 4 + 4 * k); end
    end
  endtask

  task automatic test_busy_ignore();
    measure(0, 1'b1);
    checks++; if (n_wr !== 8)      begin errors++; $display("FAIL ign_nwr: got %0d want 8", n_wr); end
    checks++; if (done_cyc !== 33) begin errors++; $display("FAIL ign_done: got %0d want 33", done_cyc); end
    checks++; if (wr_rd[7] !== 11 || wr_cyc[7] !== 32)
      begin errors++; $display("FAIL ign_last: got rd=%0d cyc=%0d want 11/32", wr_rd[7], wr_cyc[7]); end
  endtask

  task automatic test_bad_dest();
    measure(1, 1'b0);
    checks++; if (n_wr !== 7)      begin errors++; $display("FAIL bad_nwr: got %0d want 7", n_wr); end
    checks++; if (wr_rd[1] !== 7 || wr_cyc[1] !== 12)
      begin errors++; $display("FAIL bad_skip: got rd=%0d cyc=%0d want 7/12", wr_rd[1], wr_cyc[1]); end
    checks++; if (err_done !== 1'b1) begin errors++; $display("FAIL bad_err_done: got %b want 1", err_done); end
    checks++; if (done_cyc !== 33) begin errors++; $display("FAIL bad_done: got %0d want 33", done_cyc); end
    checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL bad_err_idle: got %b want 1", err[1]); end
    measure(1, 1'b0);
    checks++; if (err_c1 !== 1'b0) begin errors++; $display("FAIL bad_err_clear: got %b want 0", err_c1); end
    checks++; if (err_done !== 1'b1) begin errors++; $display("FAIL bad_err_again: got %b want 1", err_done); end
  endtask

  task automatic test_halt();
    measure(2, 1'b0);
    checks++; if (n_wr !== 3)      begin errors++; $display("FAIL halt_nwr: got %0d want 3", n_wr); end
    checks++; if (wr_rd[2] !== 7)  begin errors++; $display("FAIL halt_lastrd: got %0d want 7", wr_rd[2]); end
    checks++; if (done_cyc !== 14) begin errors++; $display("FAIL halt_done: got %0d want 14", done_cyc); end
    checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL halt_err: got %b want 0", err_done); end
  endtask

  task automatic test_mid_run_reset();
    int n_wt, n_busy;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (9) tick();
    checks++; if (rs[0] !== 4'd7 || rt[0] !== 4'd3 || aluop[0] !== 2'b01)
      begin errors++; $display("FAIL mid_issue2: got rs=%0d rt=%0d op=%b want 7/3/01", rs[0], rt[0], aluop[0]); end
    rst = 1'b0;
    #1;
    checks++; if ({busy[0], done[0], err[0], wtreg[0]} !== 4'b0000)
      begin errors++; $display("FAIL mid_ctl: got busy=%b done=%b err=%b wt=%b want 0", busy[0], done[0], err[0], wtreg[0]); end
    checks++; if ({aluop[0], rs[0], rt[0], rd[0]} !== 14'h0)
      begin errors++; $display("FAIL mid_sel: got op=%b rs=%0d rt=%0d rd=%0d want 0", aluop[0], rs[0], rt[0], rd[0]); end
    tick();
    rst = 1'b1;
    n_wt = 0;
    n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wtreg[0] === 1'b1) n_wt++;
      if (busy[0] !== 1'b0) n_busy++;
    end
    checks++; if (n_wt !== 0)   begin errors++; $display("FAIL mid_nowrite: got %0d writes want 0", n_wt); end
    checks++; if (n_busy !== 0) begin errors++; $display("FAIL mid_idle: got %0d busy cycles want 0", n_busy); end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    test_reset();
    test_first_instr();
    test_full_run();
    test_busy_ignore();
    test_bad_dest();
    test_halt();
    test_mid_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
